// File: rtl/neuron_mac_pipe.sv
// Two-stage multiply-accumulate neuron: registered product, then full-precision
// accumulate with bias add, rescale and saturation on the last element.
module neuron_mac_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int NUM_INPUTS = 4,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic signed [DATA_WIDTH-1:0] w_in,
  input  logic signed [DATA_WIDTH-1:0] bias_in,
  output logic signed [DATA_WIDTH-1:0] out,
  output logic                         valid_out,
  output logic                         ovf_out
);

  localparam int CW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int PW = 2 * DATA_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  if (ACC_WIDTH < 2*DATA_WIDTH + $clog2(NUM_INPUTS) + 1) begin : g_acc_width_check
    $error("neuron_mac_pipe: ACC_WIDTH too small for NUM_INPUTS full-precision products");
  end

  logic [CW-1:0]                count_q, count_d;
  logic signed [DATA_WIDTH-1:0] bias_q, bias_d;
  logic signed [PW-1:0]         prod_q, prod_d;
  logic                         p_valid_q, p_valid_d;
  logic                         p_last_q, p_last_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0] out_q, out_d;
  logic                         valid_out_q, valid_out_d;
  logic                         ovf_q, ovf_d;

  logic                         is_last;
  logic signed [ACC_WIDTH-1:0]  acc_next, bias_ext, sum, res;

  assign is_last = (count_q == CW'(NUM_INPUTS - 1));

  always_comb begin
    count_d   = count_q;
    bias_d    = bias_q;
    prod_d    = prod_q;
    p_valid_d = 1'b0;
    p_last_d  = p_last_q;
    if (valid_in) begin
      prod_d    = x_in * w_in;
      p_valid_d = 1'b1;
      p_last_d  = is_last;
      if (count_q == '0) bias_d = bias_in;
      count_d   = is_last ? '0 : count_q + 1'b1;
    end
  end

  always_comb begin
    acc_next    = acc_q + {{(ACC_WIDTH-PW){prod_q[PW-1]}}, prod_q};
    bias_ext    = {{(ACC_WIDTH-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q} <<< FRAC_BITS;
    sum         = acc_next + bias_ext;
    res         = sum >>> FRAC_BITS;
    acc_d       = acc_q;
    out_d       = out_q;
    valid_out_d = 1'b0;
    ovf_d       = 1'b0;
    if (p_valid_q) begin
      if (!p_last_q) begin
        acc_d = acc_next;
      end else begin
        // Clearing acc on the emitting edge lets the next vector start without a bubble.
        acc_d       = '0;
        valid_out_d = 1'b1;
        if (res > SAT_MAX) begin
          out_d = SAT_MAX[DATA_WIDTH-1:0];
          ovf_d = 1'b1;
        end else if (res < SAT_MIN) begin
          out_d = SAT_MIN[DATA_WIDTH-1:0];
          ovf_d = 1'b1;
        end else begin
          out_d = res[DATA_WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      bias_q      <= '0;
      prod_q      <= '0;
      p_valid_q   <= 1'b0;
      p_last_q    <= 1'b0;
      acc_q       <= '0;
      out_q       <= '0;
      valid_out_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      bias_q      <= bias_d;
      prod_q      <= prod_d;
      p_valid_q   <= p_valid_d;
      p_last_q    <= p_last_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      valid_out_q <= valid_out_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out       = out_q;
  assign valid_out = valid_out_q;
  assign ovf_out   = ovf_q;

endmodule

// File: tb/tb_neuron_mac_pipe.sv
// Scoreboard bench for neuron_mac_pipe: directed vectors push hand-computed
// results and the expected output edge; a negedge monitor pops and compares.
module tb_neuron_mac_pipe;

  typedef int vec_t[4];
  typedef struct {
    int   o;
    logic ovf;
    int   cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               valid_in = 1'b0;
  logic signed [15:0] x_in = '0;
  logic signed [15:0] w_in = '0;
  logic signed [15:0] bias_in = '0;
  logic signed [15:0] out;
  logic               valid_out;
  logic               ovf_out;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  neuron_mac_pipe #(
    .DATA_WIDTH(16),
    .FRAC_BITS (8),
    .NUM_INPUTS(4),
    .ACC_WIDTH (40)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .x_in     (x_in),
    .w_in     (w_in),
    .bias_in  (bias_in),
    .out      (out),
    .valid_out(valid_out),
    .ovf_out  (ovf_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (valid_out) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid_out", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out", longint'(out), longint'(e.o));
        chk("ovf_out", longint'(ovf_out), longint'(e.ovf));
        chk("latency_edge", cyc, e.cyc);
      end
    end
  end

  // Called at posedge+1; returns the index of the edge that sampled the inputs.
  task automatic drive(input logic v, input int x, input int w, input int b, output int e);
    valid_in = v;
    x_in     = 16'(x);
    w_in     = 16'(w);
    bias_in  = 16'(b);
    @(posedge clk);
    #1;
    e = cyc;
  endtask

  task automatic run_vec(input vec_t xs, input vec_t ws, input int b, input int gapmax,
                         input int exp_o, input logic exp_ovf);
    int e;
    exp_t t;
    for (int i = 0; i < 4; i++) begin
      if (gapmax > 0) begin
        int g;
        g = $urandom_range(gapmax, 0);
        for (int k = 0; k < g; k++) drive(1'b0, 0, 0, 1000, e);
      end
      drive(1'b1, xs[i], ws[i], (i == 0) ? b : 1000, e);
    end
    t.o   = exp_o;
    t.ovf = exp_ovf;
    t.cyc = e + 1;
    sb.push_back(t);
  endtask

  task automatic idle(input int n);
    int e;
    for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 0, e);
  endtask

  initial begin
    int e;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_out", longint'(out), 0);
    chk("reset_valid_out", longint'(valid_out), 0);
    chk("reset_ovf_out", longint'(ovf_out), 0);
    rst = 1'b0;
    idle(2);

    run_vec('{256, 256, 256, 256}, '{256, 512, -256, 128}, 0, 0, 640, 1'b0);
    idle(4);
    run_vec('{256, 256, 256, 256}, '{256, 512, -256, 128}, -768, 0, -128, 1'b0);
    idle(4);
    run_vec('{32767, 32767, 32767, 32767}, '{32767, 32767, 32767, 32767}, 0, 0, 32767, 1'b1);
    idle(4);
    run_vec('{32767, 32767, 32767, 32767}, '{-32768, -32768, -32768, -32768}, 0, 0, -32768, 1'b1);
    idle(4);
    run_vec('{1, 0, 0, 0}, '{-1, 0, 0, 0}, 0, 0, -1, 1'b0);
    idle(4);
    run_vec('{256, 256, 256, 256}, '{256, 512, -256, 128}, 0, 3, 640, 1'b0);
    idle(4);
    // Back-to-back vectors: expected edges end up exactly 4 apart.
    run_vec('{256, 256, 256, 256}, '{256, 512, -256, 128}, 0, 0, 640, 1'b0);
    run_vec('{256, 256, 256, 256}, '{256, 512, -256, 128}, -768, 0, -128, 1'b0);
    idle(4);

    // Abort a vector after two elements with a one-cycle reset.
    drive(1'b1, 256, 256, 0, e);
    drive(1'b1, 256, 512, 1000, e);
    rst = 1'b1;
    drive(1'b0, 0, 0, 0, e);
    chk("midreset_out", longint'(out), 0);
    chk("midreset_valid_out", longint'(valid_out), 0);
    chk("midreset_ovf_out", longint'(ovf_out), 0);
    rst = 1'b0;
    run_vec('{256, 256, 256, 256}, '{256, 512, -256, 128}, 0, 0, 640, 1'b0);
    idle(1);

    for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1);
    while (sb.size() != 0) begin
      exp_t t;
      t = sb.pop_front();
      chk("missing_valid_out", 0, 1);
    end
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
